// File: rtl/ext_pkg.sv
// Shared extension-op codes (also used by the decoder) and the multiply FSM
// state encoding for the HI/LO execute unit.
package ext_pkg;

  localparam logic [3:0] EXT_NONE  = 4'h0;
  localparam logic [3:0] EXT_MULTU = 4'h2;
  localparam logic [3:0] EXT_MFLO  = 4'h4;
  localparam logic [3:0] EXT_MFHI  = 4'h5;
  localparam logic [3:0] EXT_JR    = 4'h8;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  // Ops that depend on HI/LO and must wait for an in-flight multiply.
  function automatic logic is_hilo_op(input logic [3:0] code);
    return (code == EXT_MULTU) || (code == EXT_MFLO) || (code == EXT_MFHI);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath: one conditional add and right shift per run cycle,
// WIDTH cycles per unsigned product.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_run,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_next;

  // The carry out of the add becomes the new accumulator MSB after the shift.
  assign w_addend   = r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  assign o_done    = i_run && (r_cnt == CNT_W'(WIDTH-1));
  assign o_product = w_acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_acc   <= {{WIDTH{1'b0}}, i_b};
      r_mcand <= i_a;
      r_cnt   <= '0;
    end else if (i_run) begin
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mul_hilo_unit.sv
// Execute-stage HI/LO unit: iterative MULTU into HI/LO, MFHI/MFLO reads, and
// the pipeline stall while a HI/LO op meets an in-flight multiply.
//
// Handshake: an instruction in EX is offered when ex_valid=1; it is consumed on
// any rising edge where stall=0. A MULTU is accepted only from IDLE, so a held
// MULTU starts on the first edge after the previous multiply completes.
module mul_hilo_unit
  import ext_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ext_cont,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mul_state_e         r_state;
  logic               r_busy;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_run;
  logic               w_done;
  logic [2*WIDTH-1:0] w_product;

  assign w_accept = ex_valid && (ext_cont == EXT_MULTU) && (r_state == MUL_IDLE);
  assign w_run    = (r_state == MUL_RUN);

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept),
    .i_run     (w_run),
    .i_a       (src_a),
    .i_b       (src_b),
    .o_done    (w_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= MUL_IDLE;
      r_busy  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MUL_IDLE: begin
          if (w_accept) begin
            r_state <= MUL_RUN;
            r_busy  <= 1'b1;
          end
        end
        MUL_RUN: begin
          if (w_done) begin
            r_hi    <= w_product[2*WIDTH-1:WIDTH];
            r_lo    <= w_product[WIDTH-1:0];
            r_state <= MUL_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= MUL_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stall = r_busy && ex_valid && is_hilo_op(ext_cont);

  // No bypass: a held MFHI/MFLO reads HI/LO only once the multiply has landed.
  always_comb begin
    hilo_rdata = '0;
    if (ex_valid) begin
      case (ext_cont)
        EXT_MFHI: hilo_rdata = r_hi;
        EXT_MFLO: hilo_rdata = r_lo;
        default:  hilo_rdata = '0;
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed-vector bench for mul_hilo_unit: reset/abort, latency, stall length,
// back-to-back MULTU, ignored ops and operand sampling.
module tb_mul_hilo_unit;
  import ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  ext_cont;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hilo_rdata;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_errors = 0;
  int n_stall;

  mul_hilo_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ext_cont   (ext_cont),
    .src_a      (src_a),
    .src_b      (src_b),
    .hilo_rdata (hilo_rdata),
    .stall      (stall),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [3:0] code,
                       input logic [31:0] a, input logic [31:0] b);
    ex_valid = v;
    ext_cont = code;
    src_a    = a;
    src_b    = b;
    #1;
  endtask

  task automatic count_stall(input int budget);
    n_stall = 0;
    for (int i = 0; i < budget; i++) begin
      if (!stall) break;
      n_stall++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // 1: reset held two edges mid-run
    drive(1'b1, EXT_MULTU, 32'd100, 32'd200);
    tick();
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("t1_busy_run", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b1, EXT_MFLO, 32'd0, 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_hi", hi, 32'd0);
    check("t1_lo", lo, 32'd0);
    check("t1_stall", 32'(stall), 32'd0);

    // 2: 7*6, result lands on the 33rd edge counting the accept edge
    drive(1'b1, EXT_MULTU, 32'd7, 32'd6);
    tick();
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    for (int i = 0; i < 31; i++) tick();
    check("t2_busy_edge32", 32'(busy), 32'd1);
    check("t2_lo_edge32", lo, 32'd0);
    tick();
    check("t2_busy_edge33", 32'(busy), 32'd0);
    check("t2_lo", lo, 32'h0000002A);
    check("t2_hi", hi, 32'd0);
    drive(1'b1, EXT_MFHI, 32'd0, 32'd0);
    check("t2_mfhi", hilo_rdata, 32'd0);
    check("t2_mfhi_stall", 32'(stall), 32'd0);
    drive(1'b1, EXT_MFLO, 32'd0, 32'd0);
    check("t2_mflo", hilo_rdata, 32'h0000002A);

    // 3: max operands, MFLO held for the whole run
    drive(1'b1, EXT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    drive(1'b1, EXT_MFLO, 32'd0, 32'd0);
    count_stall(40);
    check("t3_stall_cycles", 32'(n_stall), 32'd32);
    check("t3_mflo", hilo_rdata, 32'h00000001);
    check("t3_hi", hi, 32'hFFFFFFFE);
    drive(1'b1, EXT_MFHI, 32'd0, 32'd0);
    check("t3_mfhi", hilo_rdata, 32'hFFFFFFFE);

    // 4: back-to-back MULTU; held operands must not disturb the first product
    drive(1'b1, EXT_MULTU, 32'h80000000, 32'd2);
    tick();
    drive(1'b1, EXT_MULTU, 32'd3, 32'd5);
    count_stall(40);
    check("t4_stall_cycles", 32'(n_stall), 32'd32);
    check("t4_hi1", hi, 32'd1);
    check("t4_lo1", lo, 32'd0);
    tick();
    check("t4_accept2", 32'(busy), 32'd1);
    drive(1'b1, EXT_NONE, 32'hDEADBEEF, 32'hCAFEF00D);
    wait_idle("t4_done", 40);
    check("t4_lo2", lo, 32'd15);
    check("t4_hi2", hi, 32'd0);

    // 5: invalid slot ignored; non-HI/LO ops never stall
    drive(1'b0, EXT_MULTU, 32'd9, 32'd9);
    tick();
    tick();
    check("t5_invalid_busy", 32'(busy), 32'd0);
    drive(1'b0, EXT_MFLO, 32'd0, 32'd0);
    check("t5_invalid_rdata", hilo_rdata, 32'd0);
    drive(1'b1, EXT_MULTU, 32'd9, 32'd9);
    tick();
    drive(1'b1, EXT_JR, 32'd0, 32'd0);
    check("t5_jr_stall", 32'(stall), 32'd0);
    drive(1'b1, EXT_NONE, 32'd0, 32'd0);
    check("t5_add_stall", 32'(stall), 32'd0);
    drive(1'b0, EXT_MFHI, 32'd0, 32'd0);
    check("t5_invalid_stall", 32'(stall), 32'd0);
    drive(1'b1, EXT_MFHI, 32'd0, 32'd0);
    check("t5_mfhi_stall", 32'(stall), 32'd1);
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    wait_idle("t5_done", 40);
    check("t5_lo", lo, 32'd81);

    // 6: reset at run cycle 10 aborts; next multiply is clean
    drive(1'b1, EXT_MULTU, 32'h00001234, 32'h00005678);
    tick();
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_hi", hi, 32'd0);
    check("t6_abort_lo", lo, 32'd0);
    drive(1'b1, EXT_MULTU, 32'd2, 32'd3);
    tick();
    drive(1'b0, EXT_NONE, 32'd0, 32'd0);
    wait_idle("t6_done", 40);
    check("t6_lo", lo, 32'd6);
    check("t6_hi", hi, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
